// File: rtl/ex_result_stage.sv
// EX result stage: two-entry in-order skid buffer with writeback tagging.
// Optional flag register enabled by defining FLAG_REG_EN.
module ex_result_stage #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           alu_out,
  input  logic                  alu_of,
  input  logic                  alu_cout,
  input  logic                  alu_err,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_wr_reg,
  input  logic                  in_wr_en,
  input  logic                  in_set_flags,
  output logic                  in_ready,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [15:0]           out_data,
  output logic [REG_ADDR_W-1:0] out_wr_reg,
  output logic                  out_wr_en,
  output logic [3:0]            flags,
  output logic                  err_sticky
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  typedef struct packed {
    logic [15:0]           data;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic                  wr_en;
    logic                  err;
`ifdef FLAG_REG_EN
    logic                  of;
    logic                  cout;
    logic                  sf;
`endif
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t new_e;

  logic out_valid_q, out_valid_d;
  logic in_ready_q, in_ready_d;
  logic err_q, err_d;
  logic accept, drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // An errored result must never reach the register file.
  always_comb begin
    new_e        = '0;
    new_e.data   = alu_out;
    new_e.wr_reg = in_wr_reg;
    new_e.wr_en  = in_wr_en & ~alu_err;
    new_e.err    = alu_err;
`ifdef FLAG_REG_EN
    new_e.of     = alu_of;
    new_e.cout   = alu_cout;
    new_e.sf     = in_set_flags;
`endif
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    err_d   = err_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = new_e;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case ({accept, drain})
            2'b11: head_d = new_e;
            2'b10: begin
              skid_d  = new_e;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (drain) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (drain && head_q.err) begin
        err_d = 1'b1;
      end
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = head_q.data;
  assign out_wr_reg = head_q.wr_reg;
  assign out_wr_en  = head_q.wr_en;
  assign err_sticky = err_q;

`ifdef FLAG_REG_EN
  logic [3:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (!flush && drain && head_q.sf && !head_q.err) begin
      flags_d = {head_q.data == 16'h0000, head_q.data[15],
                 head_q.of, head_q.cout};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  logic unused_flag_in;
  assign unused_flag_in = ^{in_set_flags, alu_of, alu_cout};
  assign flags = 4'b0000;
`endif

endmodule

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 Parameter REG_ADDR_W, default 3: width of the destination register index.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 alu_out  input  16  logical-unit result.
REQ-005 alu_of  input  1  logical-unit overflow.
REQ-006 alu_cout  input  1  logical-unit carry out.
REQ-007 alu_err  input  1  logical-unit illegal-operation error.
REQ-008 in_valid  input  1  upstream has a result this cycle.
REQ-009 in_wr_reg  input  REG_ADDR_W  destination register index.
REQ-010 in_wr_en  input  1  result is to be written back.
REQ-011 in_set_flags  input  1  result updates the flag register.
REQ-012 in_ready  output  1  stage accepts a result this cycle.
REQ-013 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-014 flush  input  1  synchronous discard of all held entries.
REQ-015 out_valid  output  1  head entry present.
REQ-016 out_data  output  16  head entry result.
REQ-017 out_wr_reg  output  REG_ADDR_W  head entry destination.
REQ-018 out_wr_en  output  1  head entry write enable.
REQ-019 flags  output  4  {Z,N,V,C} flag register.
REQ-020 err_sticky  output  1  set once any errored entry has drained.

Function
REQ-021 Two-entry in-order buffer (head, skid) with states EMPTY, ONE, FULL; all outputs driven from registers.
REQ-022 Accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-023 in_ready = 1 in EMPTY and ONE, 0 in FULL.
REQ-024 Latency: result accepted at edge N is visible on out_* after edge N (one cycle) when the buffer was EMPTY.
REQ-025 Transitions: EMPTY+accept->ONE; ONE+accept only->FULL; ONE+drain only->EMPTY; ONE+accept+drain->ONE with new entry as head; FULL+drain->ONE with skid promoted to head; otherwise hold.
REQ-026 Entries are never reordered, dropped, or duplicated except by flush or reset.
REQ-027 An entry captured with alu_err=1 stores wr_en=0 regardless of in_wr_en.
REQ-028 err_sticky sets on drain of an errored entry; cleared only by reset.
REQ-029 flush=1 forces EMPTY after the edge in any state; it overrides a same-cycle accept (input discarded) and drain (no err/flag update).
REQ-030 out_data, out_wr_reg, out_wr_en hold their last values when out_valid=0; consumers shall qualify them with out_valid.

Reset
REQ-031 rst_n low immediately sets: state EMPTY, out_valid 0, out_data 0, out_wr_reg 0, out_wr_en 0, flags 0, err_sticky 0, in_ready 1.
REQ-032 Reset during any state discards all entries; first accept is permitted on the first edge after rst_n rises.

Configuration
REQ-033 Macro FLAG_REG_EN defined: on drain of an entry with set_flags=1 and no error, flags <= {data==0, data[15], of, cout}; otherwise flags hold.
REQ-034 FLAG_REG_EN undefined: flag register absent, flags tied to 4'b0000, in_set_flags/alu_of/alu_cout ignored.

Verification
REQ-035 Reset, in_valid=1 alu_out=16'h1234 wr_reg=3 wr_en=1, out_ready=1 -> next cycle out_valid=1 out_data=16'h1234 out_wr_reg=3.
REQ-036 out_ready=0, push 16'h0001, 16'h0002 -> in_ready=0; third push ignored; out_ready=1 -> 16'h0001 then 16'h0002 drained in order, in_ready=1 after first drain.
REQ-037 ONE state, simultaneous accept 16'hBEEF and drain -> state stays ONE, head=16'hBEEF.
REQ-038 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flags unchanged.
REQ-039 FLAG_REG_EN: drain entry data=16'h8000 of=1 cout=1 set_flags=1 -> flags=4'b0111; data=0 -> flags Z=1.
REQ-040 Push alu_err=1 wr_en=1 -> out_wr_en=0; after drain err_sticky=1 until rst_n low.
